sound_glu_master: RTL and testbench
===================================

# sound_glu_master

Host-side bus initiator for the sound GLU register port (control, data, address-low and address-high registers). It accepts block-transfer commands and sequences the GLU register accesses, each qualified by `ph0_en`, to write or read a run of sound RAM bytes or DOC registers using GLU auto-increment. It sits between a DMA/host-CPU agent and the existing sound subsystem's `select`/`wr`/`host_addr`/`host_data_in`/`host_data_out` port.

## Interface
Parameters:
- none

Ports:
- CLK_14M  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- ph0_en  in  1  bus-slot enable; at most one GLU access per high cycle
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write to GLU, 0 = read from GLU
- cmd_ram  in  1  1 = sound RAM (control bit 6 set), 0 = DOC registers
- cmd_addr  in  16  start address
- cmd_len  in  16  byte count; 0 is legal
- vol  in  4  value placed in control bits 3:0
- wdata  in  8  write byte
- wdata_valid  in  1  write byte available
- wdata_ready  out  1  byte consumed this cycle
- rdata  out  8  read byte
- rdata_valid  out  1  one-cycle pulse; no backpressure
- select  out  1  GLU chip select strobe
- wr  out  1  GLU write strobe
- host_addr  out  2  GLU register index: 0 ctrl, 1 data, 2 addr lo, 3 addr hi
- host_data_out  out  8  data to GLU
- host_data_in  in  8  data from GLU
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

## Operation
- Handshake: a command is accepted on a cycle with `cmd_valid & cmd_ready`. All fields are latched; the remaining count is copied to a 16-bit counter.
- FSM states: IDLE, CTRL, ADLO, ADHI, POLL, DUMMY, XFER, FIN.
- IDLE: if `cmd_len==0`, go directly to FIN with no bus cycle. Otherwise go to CTRL.
- CTRL: write control = {0, cmd_ram, 1 (auto-inc), 0, vol}.
- ADLO and ADHI: write `cmd_addr[7:0]`, then `cmd_addr[15:8]`.
- After ADHI, go to POLL (see Configuration), then go to DUMMY for reads or XFER for writes.
- DUMMY: one data-register read with the result discarded, because GLU read data is pipelined by one access.
- XFER write: a slot is issued only when `wdata_valid` is high at a `ph0_en` cycle. Otherwise the slot is skipped, with no strobe and no count change. `wdata_ready` is high exactly in issued write-slot cycles.
- XFER read: every `ph0_en` cycle issues a data read.
- Each issued data access decrements the count. The access that decrements 1→0 moves the FSM to FIN.
- FIN: `done` pulses for one cycle, then return to IDLE.
- Address handling: the counter only counts. Address wrap (FFFF→0000 in RAM, 8-bit wrap in DOC) is the GLU's behaviour and is not modelled.
- Reset mid-transfer: abort to IDLE at the next edge with all strobes low. No `done` pulse. The partial transfer is not resumed.
- Reset values: `cmd_ready=1`, `busy=0`, `done=0`, `rdata=0`, `rdata_valid=0`, `select=0`, `wr=0`, `host_addr=0`, `host_data_out=0`, `wdata_ready=0`.

## Timing
- FSM state, `host_addr`, and `host_data_out` are registered.
- `select = issuing & ph0_en` and `wr = select & write-type access`. Each strobe is exactly one `CLK_14M` cycle, coincident with `ph0_en`.
- The state advances at the edge ending an issued strobe cycle. Setup therefore needs 3 `ph0_en` slots, plus 1 for DUMMY on reads.
- Read data is sampled from `host_data_in` at the edge ending the strobe cycle. `rdata` and `rdata_valid` are valid in the following cycle.
- `busy` is high from the cycle after acceptance through the FIN cycle.
- The earliest next acceptance is the cycle after FIN.

## Configuration
- SOUND_GLU_MASTER_BUSY_POLL_EN defined:
  - Before each data access (DUMMY included), POLL issues a control-register read.
  - If the sampled bit 7 is 1, re-poll at the next `ph0_en`. If 0, the next `ph0_en` slot issues the data access.
  - Polls do not decrement the count.
- Undefined: POLL is never entered. Data accesses may use consecutive `ph0_en` slots.

## Structure
- Shared package `sound_glu_pkg` holds:
  - the register-index constants (GLU_CTRL=0, GLU_DATA=1, GLU_ADLO=2, GLU_ADHI=3)
  - the control-bit positions (BUSY=7, RAM=6, AUTOINC=5)
  - the FSM state enum
- Single module with no sub-modules. The slot/strobe logic is simple enough to stay inline.

## Test plan
- Write RAM: `addr=0x1234`, `len=3`, data `A1 A2 A3`, `vol=0xF`, `ph0_en` every 14th cycle.
  - Bus shows: ctrl write `0x6F`, adlo `0x34`, adhi `0x12`, then data writes `A1 A2 A3`.
  - One `done` pulse follows.
- Read DOC: `addr=0x00E0`, `len=2`, GLU returning `55 66 77` on its three data reads.
  - Bus shows ctrl `0x20`, the address writes, and 3 data reads.
  - `rdata` pulses `66` then `77`; the first data read is discarded.
- `len=0` command: no strobe at all, `done` pulses, and `cmd_ready` returns high.
- Write stall: `wdata_valid` low for 2 `ph0_en` slots mid-transfer.
  - No strobe occurs in those slots.
  - The count is preserved and the total number of data writes equals `len`.
- With SOUND_GLU_MASTER_BUSY_POLL_EN: the GLU returns control `0x80` twice, then `0x00`.
  - 3 ctrl reads occur before each data access.
- Reset asserted after the second data write of a `len=5` write.
  - Strobes go low at the next edge, there is no `done` pulse, and `cmd_ready=1`.

Source files
------------

// File: rtl/sound_glu_pkg.sv
// Shared definitions for the sound GLU host-side initiator: register indices, control-bit
// positions and the sequencer state encoding.
package sound_glu_pkg;

  localparam logic [1:0] GLU_CTRL = 2'd0;
  localparam logic [1:0] GLU_DATA = 2'd1;
  localparam logic [1:0] GLU_ADLO = 2'd2;
  localparam logic [1:0] GLU_ADHI = 2'd3;

  localparam int unsigned BUSY    = 7;
  localparam int unsigned RAM     = 6;
  localparam int unsigned AUTOINC = 5;

  typedef enum logic [2:0] {
    StIdle,
    StCtrl,
    StAdlo,
    StAdhi,
    StPoll,
    StDummy,
    StXfer,
    StFin
  } glu_state_e;

  // Control register image: auto-increment always on, volume in the low nibble.
  function automatic logic [7:0] ctrl_byte(input logic ram, input logic [3:0] vol);
    logic [7:0] b;
    b          = {4'h0, vol};
    b[RAM]     = ram;
    b[AUTOINC] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/sound_glu_master_if.sv
// Command, write/read data stream and GLU register-port signals of sound_glu_master.
// The master modport is the initiator's view; slave is the host/GLU environment's view.
interface sound_glu_master_if;

  logic        ph0_en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_ram;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [3:0]  vol;
  logic [7:0]  wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        select;
  logic        wr;
  logic [1:0]  host_addr;
  logic [7:0]  host_data_out;
  logic [7:0]  host_data_in;
  logic        busy;
  logic        done;

  modport master (
    input  ph0_en, cmd_valid, cmd_write, cmd_ram, cmd_addr, cmd_len, vol,
    input  wdata, wdata_valid, host_data_in,
    output cmd_ready, wdata_ready, rdata, rdata_valid,
    output select, wr, host_addr, host_data_out, busy, done
  );

  modport slave (
    output ph0_en, cmd_valid, cmd_write, cmd_ram, cmd_addr, cmd_len, vol,
    output wdata, wdata_valid, host_data_in,
    input  cmd_ready, wdata_ready, rdata, rdata_valid,
    input  select, wr, host_addr, host_data_out, busy, done
  );

endinterface

// File: rtl/sound_glu_master.sv
// Block-transfer initiator for the sound GLU register port (ctrl/data/addr-lo/addr-hi).
// Optional busy polling before every data access: define SOUND_GLU_MASTER_BUSY_POLL_EN.
module sound_glu_master
  import sound_glu_pkg::*;
(
  input logic                CLK_14M,
  input logic                reset,
  sound_glu_master_if.master bus
);

  glu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  haddr_q, haddr_d;
  logic [7:0]  hdata_q, hdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        issuing;
  logic        write_type;
`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
  logic        dummy_done_q, dummy_done_d;
`endif

  always_comb begin
    issuing    = 1'b0;
    write_type = 1'b0;
    unique case (state_q)
      StCtrl, StAdlo, StAdhi: begin
        issuing    = 1'b1;
        write_type = 1'b1;
      end
      StPoll, StDummy: issuing = 1'b1;
      // A write slot is only used when a byte is actually on offer.
      StXfer: begin
        issuing    = !write_q || bus.wdata_valid;
        write_type = write_q;
      end
      default: issuing = 1'b0;
    endcase
  end

  assign bus.select        = issuing & bus.ph0_en;
  assign bus.wr            = bus.select & write_type;
  assign bus.wdata_ready   = bus.select & (state_q == StXfer) & write_q;
  assign bus.host_addr     = haddr_q;
  assign bus.host_data_out = (state_q == StXfer && write_q) ? bus.wdata : hdata_q;
  assign bus.cmd_ready     = (state_q == StIdle);
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rdata         = rdata_q;
  assign bus.rdata_valid   = rvalid_q;

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    haddr_d  = haddr_q;
    hdata_d  = hdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
    dummy_done_d = dummy_done_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          write_d = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          cnt_d   = bus.cmd_len;
`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
          dummy_done_d = 1'b0;
`endif
          if (bus.cmd_len == 16'd0) begin
            state_d = StFin;
          end else begin
            state_d = StCtrl;
            haddr_d = GLU_CTRL;
            hdata_d = ctrl_byte(bus.cmd_ram, bus.vol);
          end
        end
      end
      StCtrl: begin
        if (bus.select) begin
          state_d = StAdlo;
          haddr_d = GLU_ADLO;
          hdata_d = addr_q[7:0];
        end
      end
      StAdlo: begin
        if (bus.select) begin
          state_d = StAdhi;
          haddr_d = GLU_ADHI;
          hdata_d = addr_q[15:8];
        end
      end
      StAdhi: begin
        if (bus.select) begin
          hdata_d = 8'h00;
`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
          state_d = StPoll;
          haddr_d = GLU_CTRL;
`else
          state_d = write_q ? StXfer : StDummy;
          haddr_d = GLU_DATA;
`endif
        end
      end
`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
      StPoll: begin
        if (bus.select && !bus.host_data_in[BUSY]) begin
          state_d = (write_q || dummy_done_q) ? StXfer : StDummy;
          haddr_d = GLU_DATA;
        end
      end
`endif
      // Primes the GLU read pipeline; the byte returned here is stale.
      StDummy: begin
        if (bus.select) begin
`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
          state_d      = StPoll;
          haddr_d      = GLU_CTRL;
          dummy_done_d = 1'b1;
`else
          state_d = StXfer;
`endif
        end
      end
      StXfer: begin
        if (bus.select) begin
          cnt_d = cnt_q - 16'd1;
          if (!write_q) begin
            rdata_d  = bus.host_data_in;
            rvalid_d = 1'b1;
          end
          if (cnt_q == 16'd1) begin
            state_d = StFin;
            haddr_d = GLU_CTRL;
            hdata_d = 8'h00;
          end else begin
`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
            state_d = StPoll;
            haddr_d = GLU_CTRL;
`endif
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      addr_q   <= 16'h0000;
      cnt_q    <= 16'h0000;
      haddr_q  <= GLU_CTRL;
      hdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      haddr_q  <= haddr_d;
      hdata_q  <= hdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      dummy_done_q <= 1'b0;
    end else begin
      dummy_done_q <= dummy_done_d;
    end
  end
`endif

endmodule

// File: tb/tb_sound_glu_master.sv
// Bench for sound_glu_master: a transaction-level model predicts every GLU strobe and rdata
// byte; a negedge monitor checks the DUT against it each cycle.
module tb_sound_glu_master;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_ev_t;

`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
  localparam int RdStrobes = 12;
`else
  localparam int RdStrobes = 3;
`endif

  logic clk = 1'b0;
  logic reset;

  sound_glu_master_if bus ();

  sound_glu_master dut (
    .CLK_14M (clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  bus_ev_t    exp_ev[$];
  logic [7:0] resp_q[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wq[$];
  logic [7:0] wlog[$];
  logic [7:0] rlog[$];
  logic [7:0] data_buf[$];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int strobe_cnt = 0;
  int rd_strobe_cnt = 0;
  int writes_seen = 0;
  int wr_taken = 0;
  int stall_at = -1;
  int stall_len = 0;
  int stall_used = 0;
  int ph0_cnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bus_ev_t mk(input logic wr, input logic [1:0] addr, input logic [7:0] data);
    bus_ev_t e;
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  // Expected GLU traffic for one command, derived from the register-port protocol.
  task automatic model(input bit write, input bit ram, input logic [15:0] addr,
                       input logic [15:0] len, input logic [3:0] vol);
    int n;
    if (len == 16'd0) return;
    exp_ev.push_back(mk(1'b1, 2'd0, {1'b0, ram, 1'b1, 1'b0, vol}));
    exp_ev.push_back(mk(1'b1, 2'd2, addr[7:0]));
    exp_ev.push_back(mk(1'b1, 2'd3, addr[15:8]));
    n = write ? int'(len) : int'(len) + 1;
    for (int i = 0; i < n; i++) begin
`ifdef SOUND_GLU_MASTER_BUSY_POLL_EN
      for (int p = 0; p < 3; p++) begin
        exp_ev.push_back(mk(1'b0, 2'd0, 8'h00));
        resp_q.push_back(p < 2 ? 8'h80 : 8'h00);
      end
`endif
      if (write) begin
        exp_ev.push_back(mk(1'b1, 2'd1, data_buf[i]));
        wq.push_back(data_buf[i]);
      end else begin
        exp_ev.push_back(mk(1'b0, 2'd1, 8'h00));
        resp_q.push_back(data_buf[i]);
        if (i > 0) exp_rd.push_back(data_buf[i]);
      end
    end
  endtask

  initial begin
    bus.ph0_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph0_cnt    = (ph0_cnt == 13) ? 0 : ph0_cnt + 1;
      bus.ph0_en = (ph0_cnt == 13);
    end
  end

  // Write-byte source: pops one byte per consumed slot, withholds bytes during a stall window.
  initial begin
    int popped;
    popped          = 0;
    bus.wdata       = 8'h00;
    bus.wdata_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      while (popped < wr_taken) begin
        if (wq.size() > 0) void'(wq.pop_front());
        popped++;
      end
      bus.wdata_valid = (wq.size() > 0) && !(stall_used < stall_len && writes_seen == stall_at);
      bus.wdata       = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  initial begin
    bus_ev_t ev;
    bus.host_data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.select) begin
        strobe_cnt++;
        chk("strobe_in_ph0", 16'(bus.ph0_en), 16'd1);
        if (!bus.wr) begin
          rd_strobe_cnt++;
          if (resp_q.size() > 0) begin
            bus.host_data_in = resp_q.pop_front();
          end else begin
            vectors++;
            miscompares++;
            $display("FAIL read_response: got read of reg %0d, expected no read", bus.host_addr);
          end
        end
        if (exp_ev.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got wr=%0b reg=%0d, expected none", bus.wr,
                   bus.host_addr);
        end else begin
          ev = exp_ev.pop_front();
          chk("strobe_wr", 16'(bus.wr), 16'(ev.wr));
          chk("strobe_reg", 16'(bus.host_addr), 16'(ev.addr));
          if (ev.wr) chk("strobe_data", 16'(bus.host_data_out), 16'(ev.data));
        end
        if (bus.wr) begin
          wlog.push_back(bus.host_data_out);
          if (bus.host_addr == 2'd1) writes_seen++;
        end
      end else begin
        chk("wr_without_select", 16'(bus.wr), 16'd0);
      end
      chk("wdata_ready", 16'(bus.wdata_ready),
          16'(bus.select & bus.wr & (bus.host_addr == 2'd1)));
      if (bus.wdata_ready) wr_taken++;
      chk("cmd_ready_vs_busy", 16'(bus.cmd_ready), 16'(!bus.busy));
      if (bus.rdata_valid) begin
        rlog.push_back(bus.rdata);
        if (exp_rd.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rdata_valid: got pulse with %0h, expected none", bus.rdata);
        end else begin
          chk("rdata", 16'(bus.rdata), 16'(exp_rd.pop_front()));
        end
      end
      if (bus.done) done_cnt++;
      if (stall_used < stall_len && writes_seen == stall_at && bus.ph0_en && !bus.wdata_valid)
      begin
        chk("stall_no_write", 16'(bus.select & bus.wr), 16'd0);
        stall_used++;
      end
    end
  end

  task automatic run_cmd(input bit write, input bit ram, input logic [15:0] addr,
                         input logic [15:0] len, input logic [3:0] vol);
    @(posedge clk);
    #2;
    model(write, ram, addr, len, vol);
    bus.cmd_write = write;
    bus.cmd_ram   = ram;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.vol       = vol;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", 16'(bus.cmd_ready), 16'd1);
    @(posedge clk);
    #2;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done in 3000 cycles, expected done", name);
    end
    @(posedge clk);
    @(negedge clk);
    chk({name, "_events_left"}, 16'(exp_ev.size()), 16'd0);
    chk({name, "_rdata_left"}, 16'(exp_rd.size()), 16'd0);
    chk({name, "_cmd_ready"}, 16'(bus.cmd_ready), 16'd1);
    chk({name, "_busy"}, 16'(bus.busy), 16'd0);
  endtask

  initial begin
    int s0;
    int w0;
    int d0;
    int n;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_ram   = 1'b0;
    bus.cmd_addr  = 16'h0000;
    bus.cmd_len   = 16'h0000;
    bus.vol       = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 16'(bus.cmd_ready), 16'd1);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_rdata", 16'(bus.rdata), 16'd0);
    chk("rst_rdata_valid", 16'(bus.rdata_valid), 16'd0);
    chk("rst_select", 16'(bus.select), 16'd0);
    chk("rst_wr", 16'(bus.wr), 16'd0);
    chk("rst_host_addr", 16'(bus.host_addr), 16'd0);
    chk("rst_host_data_out", 16'(bus.host_data_out), 16'd0);
    chk("rst_wdata_ready", 16'(bus.wdata_ready), 16'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    data_buf = '{8'hA1, 8'hA2, 8'hA3};
    run_cmd(1'b1, 1'b1, 16'h1234, 16'd3, 4'hF);
    wait_done("wr_ram");
    chk("wr_ram_ctrl", 16'(wlog[0]), 16'h006F);
    chk("wr_ram_adlo", 16'(wlog[1]), 16'h0034);
    chk("wr_ram_adhi", 16'(wlog[2]), 16'h0012);
    chk("wr_ram_d0", 16'(wlog[3]), 16'h00A1);
    chk("wr_ram_d1", 16'(wlog[4]), 16'h00A2);
    chk("wr_ram_d2", 16'(wlog[5]), 16'h00A3);

    data_buf = '{8'h55, 8'h66, 8'h77};
    s0 = rd_strobe_cnt;
    run_cmd(1'b0, 1'b0, 16'h00E0, 16'd2, 4'h0);
    wait_done("rd_doc");
    chk("rd_doc_ctrl", 16'(wlog[6]), 16'h0020);
    chk("rd_doc_adlo", 16'(wlog[7]), 16'h00E0);
    chk("rd_doc_adhi", 16'(wlog[8]), 16'h0000);
    chk("rd_doc_r0", 16'(rlog[0]), 16'h0066);
    chk("rd_doc_r1", 16'(rlog[1]), 16'h0077);
    chk("rd_doc_reads", 16'(rd_strobe_cnt - s0), 16'(RdStrobes));

    s0 = strobe_cnt;
    run_cmd(1'b1, 1'b1, 16'h4000, 16'd0, 4'h3);
    wait_done("len0");
    chk("len0_strobes", 16'(strobe_cnt - s0), 16'd0);

    data_buf  = '{8'h11, 8'h22, 8'h33, 8'h44};
    w0        = writes_seen;
    stall_at  = w0 + 2;
    stall_len = stall_used + 2;
    run_cmd(1'b1, 1'b1, 16'h0100, 16'd4, 4'h5);
    wait_done("stall");
    chk("stall_writes", 16'(writes_seen - w0), 16'd4);
    chk("stall_slots", 16'(stall_used), 16'(stall_len));
    stall_at = -1;

    data_buf = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    w0 = writes_seen;
    d0 = done_cnt;
    run_cmd(1'b1, 1'b1, 16'h2000, 16'd5, 4'h0);
    for (n = 0; n < 2000; n++) begin
      @(posedge clk);
      #3;
      if (writes_seen - w0 >= 2) break;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL abort_wait: got %0d data writes, expected 2", writes_seen - w0);
    end
    reset = 1'b1;
    exp_ev.delete();
    resp_q.delete();
    wq.delete();
    exp_rd.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_select", 16'(bus.select), 16'd0);
    chk("abort_wr", 16'(bus.wr), 16'd0);
    chk("abort_cmd_ready", 16'(bus.cmd_ready), 16'd1);
    chk("abort_busy", 16'(bus.busy), 16'd0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 16'(done_cnt - d0), 16'd0);
    chk("abort_writes", 16'(writes_seen - w0), 16'd2);
    chk("abort_idle", 16'(bus.cmd_ready), 16'd1);

    chk("done_total", 16'(done_cnt), 16'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
